// File: rtl/bat_bus_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bat_bus_loader: halts the BatAmateur core and runs host RAM load/dump commands.
// Optional running write checksum: define BAT_LOADER_CHKSUM_EN.   Rev 1.0
// ---------------------------------------------------------------------------
module bat_bus_loader #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int MEM_WAIT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt_req,
  input  logic              cpu_idle,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              halt,
  output logic [ADDR_W-1:0] addr,
  output logic              ram_en,
  output logic              ram_rw,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] chksum
);

  localparam logic [1:0] OP_SETADDR = 2'b00;
  localparam logic [1:0] OP_WRITE   = 2'b01;
  localparam logic [1:0] OP_READ    = 2'b10;
  localparam logic [1:0] OP_RESUME  = 2'b11;
  localparam logic [3:0] WAIT_LAST  = 4'(MEM_WAIT);

  typedef enum logic [2:0] {
    S_RUN     = 3'd0,
    S_HALTING = 3'd1,
    S_HALTED  = 3'd2,
    S_WRITE   = 3'd3,
    S_READ    = 3'd4
  } state_t;

  state_t      state;
  logic        halt_req_q;
  logic [3:0]  wait_cnt;
  logic        accept;
  logic        access_last;

  assign accept      = cmd_valid && cmd_ready;
  assign access_last = (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_RUN;
      // Resetting the history high masks a halt_req that is held through reset.
      halt_req_q <= 1'b1;
      wait_cnt   <= 4'd0;
      halt       <= 1'b0;
      cmd_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      addr       <= '0;
      ram_en     <= 1'b0;
      ram_rw     <= 1'b0;
      bus_out    <= '0;
      bus_oe     <= 1'b0;
    end else begin
      halt_req_q <= halt_req;
      rsp_valid  <= 1'b0;
      case (state)
        S_RUN: begin
          if (halt_req && !halt_req_q) begin
            state <= S_HALTING;
            halt  <= 1'b1;
          end
        end
        S_HALTING: begin
          if (cpu_idle) begin
            state     <= S_HALTED;
            cmd_ready <= 1'b1;
          end
        end
        S_HALTED: begin
          if (accept) begin
            case (cmd_op)
              OP_SETADDR: addr <= cmd_data[ADDR_W-1:0];
              OP_WRITE: begin
                state     <= S_WRITE;
                bus_out   <= cmd_data;
                cmd_ready <= 1'b0;
                ram_en    <= 1'b1;
                ram_rw    <= 1'b1;
                bus_oe    <= 1'b1;
                wait_cnt  <= 4'd0;
              end
              OP_READ: begin
                state     <= S_READ;
                cmd_ready <= 1'b0;
                ram_en    <= 1'b1;
                ram_rw    <= 1'b0;
                wait_cnt  <= 4'd0;
              end
              default: begin
                state     <= S_RUN;
                halt      <= 1'b0;
                cmd_ready <= 1'b0;
              end
            endcase
          end
        end
        S_WRITE: begin
          if (access_last) begin
            state     <= S_HALTED;
            cmd_ready <= 1'b1;
            ram_en    <= 1'b0;
            ram_rw    <= 1'b0;
            bus_oe    <= 1'b0;
            addr      <= addr + ADDR_W'(1);
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        S_READ: begin
          if (access_last) begin
            state     <= S_HALTED;
            cmd_ready <= 1'b1;
            ram_en    <= 1'b0;
            rsp_data  <= bus_in;
            rsp_valid <= 1'b1;
            addr      <= addr + ADDR_W'(1);
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        default: begin
          state     <= S_RUN;
          halt      <= 1'b0;
          cmd_ready <= 1'b0;
          ram_en    <= 1'b0;
          ram_rw    <= 1'b0;
          bus_oe    <= 1'b0;
        end
      endcase
    end
  end

`ifdef BAT_LOADER_CHKSUM_EN
  logic chk_clear;
  logic chk_add;

  // The top data bit of a SETADDR doubles as the checksum clear request.
  assign chk_clear = (state == S_HALTED) && accept && (cmd_op == OP_SETADDR)
                     && cmd_data[DATA_W-1];
  assign chk_add   = (state == S_WRITE) && access_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chksum <= '0;
    end else if (chk_clear) begin
      chksum <= '0;
    end else if (chk_add) begin
      chksum <= chksum + bus_out;
    end
  end
`else
  assign chksum = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bat_bus_loader.sv
`default_nettype none
// Scoreboard bench for bat_bus_loader with MEM_WAIT=2.
module tb_bat_bus_loader;
  localparam int MW = 2;
  localparam logic [1:0] SETADDR = 2'b00;
  localparam logic [1:0] WRITE   = 2'b01;
  localparam logic [1:0] READ    = 2'b10;
  localparam logic [1:0] RESUME  = 2'b11;

  logic        clk = 1'b0;
  logic        rst, halt_req, cpu_idle, cmd_valid;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_data, bus_in;
  logic        cmd_ready, rsp_valid, halt, ram_en, ram_rw, bus_oe;
  logic [15:0] rsp_data, addr, bus_out, chksum;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mon_exp;

  bat_bus_loader #(.DATA_W(16), .ADDR_W(16), .MEM_WAIT(MW)) dut (
    .clk(clk), .rst(rst), .halt_req(halt_req), .cpu_idle(cpu_idle),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .halt(halt), .addr(addr), .ram_en(ram_en), .ram_rw(ram_rw),
    .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in), .chksum(chksum)
  );

  always #5 clk = ~clk;

  // Read responses are checked against the queue as they appear.
  always @(negedge clk) begin
    if (!rst && rsp_valid === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL rsp_unexpected: got %h with nothing expected", rsp_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (rsp_data !== mon_exp) begin
          fails++;
          $display("FAIL rsp_data: got %h expected %h", rsp_data, mon_exp);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Returns one cycle after the accepting edge.
  task automatic send_cmd(input logic [1:0] op, input logic [15:0] d);
    int n = 0;
    cmd_op    = op;
    cmd_data  = d;
    cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && n < 50) begin
      tick;
      n++;
    end
    if (n >= 50) begin
      tests++;
      fails++;
      $display("FAIL cmd_timeout: op %0d never accepted, cmd_ready=%b", op, cmd_ready);
    end
    tick;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_access_done;
    int n = 0;
    while (ram_en === 1'b1 && n < 20) begin
      tick;
      n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; halt_req = 1'b1; cpu_idle = 1'b0; cmd_valid = 1'b0;
    cmd_op = 2'b00; cmd_data = 16'h0000; bus_in = 16'h0000;
    repeat (3) tick;
    tests++;
    if ({halt, cmd_ready, rsp_valid, ram_en, ram_rw, bus_oe} !== 6'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {halt, cmd_ready, rsp_valid, ram_en, ram_rw, bus_oe});
    end
    tests++;
    if (addr !== 16'h0 || rsp_data !== 16'h0 || bus_out !== 16'h0 || chksum !== 16'h0) begin
      fails++;
      $display("FAIL reset_data: addr=%h rsp=%h bus_out=%h chk=%h expected all 0",
               addr, rsp_data, bus_out, chksum);
    end
    rst = 1'b0;
    repeat (3) tick;
    tests++;
    if (halt !== 1'b0) begin
      fails++;
      $display("FAIL held_req_no_halt: halt=%b expected 0", halt);
    end
    halt_req = 1'b0;
    tick;
    halt_req = 1'b1;
    tick;
    tests++;
    if (halt !== 1'b1) begin
      fails++;
      $display("FAIL halt_on_edge: halt=%b expected 1", halt);
    end
  endtask

  task automatic test_halt;
    logic bad = 1'b0;
    repeat (5) begin
      if (halt !== 1'b1 || cmd_ready !== 1'b0) bad = 1'b1;
      tick;
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL halting_hold: halt/cmd_ready wrong while waiting for idle, got bad=%b expected 0", bad);
    end
    cpu_idle = 1'b1;
    tick;
    cpu_idle = 1'b0;
    tests++;
    if (cmd_ready !== 1'b1 || halt !== 1'b1) begin
      fails++;
      $display("FAIL halted_ready: cmd_ready=%b halt=%b expected 1 1", cmd_ready, halt);
    end
  endtask

  task automatic test_write;
    logic [15:0] wd[2] = '{16'hBEEF, 16'h1234};
    send_cmd(SETADDR, 16'h0010);
    tests++;
    if (addr !== 16'h0010) begin
      fails++;
      $display("FAIL setaddr: addr=%h expected 0010", addr);
    end
    for (int k = 0; k < 2; k++) begin
      int cnt = 0;
      int n = 0;
      logic bad = 1'b0;
      send_cmd(WRITE, wd[k]);
      while (ram_en === 1'b1 && n < 20) begin
        if (!(ram_rw === 1'b1 && bus_oe === 1'b1 && addr === 16'h0010 + 16'(k) && bus_out === wd[k]))
          bad = 1'b1;
        cnt++;
        tick;
        n++;
      end
      tests++;
      if (cnt != MW + 1 || bad) begin
        fails++;
        $display("FAIL write_strobe[%0d]: cycles=%0d bad=%b expected %0d cycles bad=0", k, cnt, bad, MW + 1);
      end
      tests++;
      if (cmd_ready !== 1'b1 || bus_oe !== 1'b0 || ram_rw !== 1'b0) begin
        fails++;
        $display("FAIL write_return[%0d]: ready=%b oe=%b rw=%b expected 1 0 0", k, cmd_ready, bus_oe, ram_rw);
      end
    end
    tests++;
    if (addr !== 16'h0012) begin
      fails++;
      $display("FAIL write_addr: addr=%h expected 0012", addr);
    end
  endtask

  task automatic test_read;
    logic [15:0] rv[2] = '{16'hBEEF, 16'h5A5A};
    send_cmd(SETADDR, 16'h0010);
    for (int k = 0; k < 2; k++) begin
      int cyc = 1;
      logic bad = 1'b0;
      exp_q.push_back(rv[k]);
      bus_in = 16'h0000;
      send_cmd(READ, 16'h0000);
      while (rsp_valid !== 1'b1 && cyc < 20) begin
        if (ram_en !== 1'b1 || ram_rw !== 1'b0 || bus_oe !== 1'b0) bad = 1'b1;
        bus_in = (cyc == MW + 1) ? rv[k] : 16'h0000;
        tick;
        cyc++;
      end
      tests++;
      if (cyc != MW + 2 || bad) begin
        fails++;
        $display("FAIL read_latency[%0d]: rsp at cycle %0d bad=%b expected %0d bad=0", k, cyc, bad, MW + 2);
      end
      bus_in = 16'h0000;
      tick;
      tests++;
      if (rsp_valid !== 1'b0 || rsp_data !== rv[k] || addr !== 16'h0011 + 16'(k)) begin
        fails++;
        $display("FAIL read_after[%0d]: valid=%b data=%h addr=%h expected 0 %h %h",
                 k, rsp_valid, rsp_data, addr, rv[k], 16'h0011 + 16'(k));
      end
    end
  endtask

  task automatic test_wrap_resume;
    send_cmd(SETADDR, 16'hFFFF);
    send_cmd(WRITE, 16'h0001);
    wait_access_done;
    tests++;
    if (addr !== 16'h0000) begin
      fails++;
      $display("FAIL addr_wrap: addr=%h expected 0000", addr);
    end
    send_cmd(RESUME, 16'h0000);
    tests++;
    if (halt !== 1'b0 || ram_en !== 1'b0 || bus_oe !== 1'b0 || cmd_ready !== 1'b0) begin
      fails++;
      $display("FAIL resume: halt=%b en=%b oe=%b ready=%b expected 0 0 0 0", halt, ram_en, bus_oe, cmd_ready);
    end
  endtask

  task automatic test_chksum;
    logic [15:0] exp_chk;
    cmd_valid = 1'b1; cmd_op = SETADDR; cmd_data = 16'h8000;
    repeat (3) tick;
    cmd_valid = 1'b0;
    tests++;
    if (cmd_ready !== 1'b0 || addr !== 16'h0000 || halt !== 1'b0) begin
      fails++;
      $display("FAIL run_ignores_cmd: ready=%b addr=%h halt=%b expected 0 0000 0", cmd_ready, addr, halt);
    end
    halt_req = 1'b0;
    tick;
    halt_req = 1'b1;
    cpu_idle = 1'b1;
    tick;
    tick;
    cpu_idle = 1'b0;
    send_cmd(SETADDR, 16'h8000);
    tests++;
    if (addr !== 16'h8000) begin
      fails++;
      $display("FAIL setaddr_clr: addr=%h expected 8000", addr);
    end
    send_cmd(WRITE, 16'hFFFF);
    wait_access_done;
    send_cmd(WRITE, 16'h0003);
    wait_access_done;
`ifdef BAT_LOADER_CHKSUM_EN
    exp_chk = 16'h0002;
`else
    exp_chk = 16'h0000;
`endif
    tests++;
    if (chksum !== exp_chk || addr !== 16'h8002) begin
      fails++;
      $display("FAIL chksum: chk=%h addr=%h expected %h 8002", chksum, addr, exp_chk);
    end
  endtask

  initial begin
    test_reset;
    test_halt;
    test_write;
    test_read;
    test_wrap_resume;
    test_chksum;
    repeat (2) tick;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL rsp_missing: %0d responses outstanding expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
